// File: rtl/if_stage_if.sv
// IF-stage bus bundle: instruction-memory port and IF/ID register outputs.
// The master side is the fetch stage. The slave side is imem and the ID consumer.
interface if_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] ifid_pc;
  logic [DATA_WIDTH-1:0] ifid_pc4;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic                  ifid_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output ifid_pc,
    output ifid_pc4,
    output ifid_instr,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  ifid_pc,
    input  ifid_pc4,
    input  ifid_instr,
    input  ifid_valid
  );
endinterface

// File: rtl/if_stage.sv
// rv32i instruction-fetch stage with PC, IF/ID register and a BOOT/RUN/HALT FSM.
// Trap and redirect flush IF/ID; stall freezes the PC and IF/ID.
module if_stage #(
  parameter int                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_en,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  trap_en,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  halt_req,
  input  logic                  resume,
  if_stage_if.master            bus,
  output logic                  fetch_misalign,
  output logic [31:0]           fetch_cnt,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic                  mis_q, mis_d;
  logic [31:0]           cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] tgt;
  logic [DATA_WIDTH-1:0] tgt_al;
  logic                  tgt_mis;
  logic [DATA_WIDTH-1:0] pc_plus4;

  // Trap outranks redirect, so it owns the shared target mux.
  assign tgt      = trap_en ? trap_pc : redirect_pc;
  assign tgt_al   = {tgt[DATA_WIDTH-1:2], 2'b00};
  assign tgt_mis  = |tgt[1:0];
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    mis_d        = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_BOOT: begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        if (trap_en || redirect_en) begin
          pc_d         = tgt_al;
          mis_d        = tgt_mis;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (halt_req) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_instr_d = bus.imem_rdata;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          cnt_d        = cnt_q + 32'd1;
        end
        if (halt_req && !trap_en) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (trap_en) begin
          pc_d  = tgt_al;
          mis_d = tgt_mis;
        end
        if (resume) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      mis_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      mis_q        <= mis_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_pc4   = ifid_pc4_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign fetch_misalign = mis_q;
  assign fetch_cnt      = cnt_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an address-derived imem model.
// Fetched PCs are queued when driven and compared as IF/ID loads them.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        trap_en;
  logic [31:0] trap_pc;
  logic        halt_req;
  logic        resume;
  logic        fetch_misalign;
  logic [31:0] fetch_cnt;
  logic        halted;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_cnt;

  if_stage_if #(.DATA_WIDTH(32)) bus ();

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_rdata = mem(bus.imem_addr);

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .trap_en        (trap_en),
    .trap_pc        (trap_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .bus            (bus),
    .fetch_misalign (fetch_misalign),
    .fetch_cnt      (fetch_cnt),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back(pc);
  endtask

  task automatic tick();
    logic [31:0] p;
    @(posedge clk);
    #1;
    if (fetch_cnt !== last_cnt) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_load", fetch_cnt, last_cnt);
      end else begin
        p = exp_q.pop_front();
        chk("sb_pc", bus.ifid_pc, p);
        chk("sb_pc4", bus.ifid_pc4, p + 32'd4);
        chk("sb_instr", bus.ifid_instr, mem(p));
        chk("sb_valid", {31'd0, bus.ifid_valid}, 32'd1);
      end
    end
    last_cnt = fetch_cnt;
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    trap_en     = 1'b0;
    trap_pc     = '0;
    halt_req    = 1'b0;
    resume      = 1'b0;
    last_cnt    = '0;

    #12;
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst_instr", bus.ifid_instr, NOP);
    chk("rst_pc", bus.ifid_pc, 32'h0);
    chk("rst_pc4", bus.ifid_pc4, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mis", {31'd0, fetch_misalign}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("boot_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("boot_addr", bus.imem_addr, 32'h0);

    push(32'h0); tick();
    push(32'h4); tick();
    push(32'h8); tick();
    chk("run3_cnt", fetch_cnt, 32'd3);
    chk("run3_addr", bus.imem_addr, 32'hC);
    push(32'hC); tick();
    chk("run4_addr", bus.imem_addr, 32'h10);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", bus.imem_addr, 32'h10);
      chk("stall_pc", bus.ifid_pc, 32'hC);
      chk("stall_cnt", fetch_cnt, 32'd4);
    end
    stall = 1'b0;
    push(32'h10); tick();
    chk("unstall_addr", bus.imem_addr, 32'h14);

    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    stall       = 1'b1;
    tick();
    chk("redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("redir_instr", bus.ifid_instr, NOP);
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_pc_hold", bus.ifid_pc, 32'h10);
    redirect_en = 1'b0;
    stall       = 1'b0;
    push(32'h100); tick();
    chk("redir_cnt", fetch_cnt, 32'd6);

    trap_en     = 1'b1;
    trap_pc     = 32'h80;
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("trap_addr", bus.imem_addr, 32'h80);
    chk("trap_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("trap_mis", {31'd0, fetch_misalign}, 32'd0);
    trap_en     = 1'b0;
    redirect_en = 1'b0;
    push(32'h80); tick();

    redirect_en = 1'b1;
    redirect_pc = 32'h202;
    tick();
    chk("mis_addr", bus.imem_addr, 32'h200);
    chk("mis_pulse", {31'd0, fetch_misalign}, 32'd1);
    redirect_en = 1'b0;
    push(32'h200); tick();
    chk("mis_clear", {31'd0, fetch_misalign}, 32'd0);
    chk("mis_cnt", fetch_cnt, 32'd8);

    halt_req = 1'b1;
    tick();
    chk("halt_on", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("halt_addr", bus.imem_addr, 32'h204);
    tick();
    chk("halt_hold", bus.imem_addr, 32'h204);
    chk("halt_cnt", fetch_cnt, 32'd8);
    trap_en = 1'b1;
    trap_pc = 32'h40;
    tick();
    chk("halt_trap_st", {31'd0, halted}, 32'd1);
    chk("halt_trap_addr", bus.imem_addr, 32'h40);
    trap_en = 1'b0;
    resume  = 1'b1;
    tick();
    chk("resume_off", {31'd0, halted}, 32'd0);
    chk("resume_addr", bus.imem_addr, 32'h40);
    resume   = 1'b0;
    halt_req = 1'b0;
    push(32'h40); tick();
    chk("resume_cnt", fetch_cnt, 32'd9);

    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    push(32'hFFFF_FFFC); tick();
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_pc4", bus.ifid_pc4, 32'h0);
    push(32'h0); tick();
    chk("wrap_cnt", fetch_cnt, 32'd11);

    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("arst_instr", bus.ifid_instr, NOP);
    chk("arst_pc", bus.ifid_pc, 32'h0);
    chk("arst_cnt", fetch_cnt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    stall    = 1'b0;
    last_cnt = '0;
    tick();
    chk("reboot_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("reboot_addr", bus.imem_addr, 32'h0);
    push(32'h0); tick();
    push(32'h4); tick();
    chk("reboot_cnt", fetch_cnt, 32'd2);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
